round_timer_ctrl: RTL and testbench

- Game-round countdown controller for the math game; sequences the 1 ms tick generator (drives its enable, consumes its 1-cycle tick output).
- Converts ms ticks to whole seconds and counts a loaded round time down to zero with start/pause/abort control.
- Provides seconds remaining (binary and BCD for the 7-segment display), a low-time warning, and a timeout pulse to the game FSM.

---
 rtl/round_timer_ctrl.sv | 132 +++++++++++++
 tb/tb_round_timer_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_timer_ctrl.sv
// Round countdown controller for the math game.
// Turns 1 ms ticks into whole seconds and signals timeout.
module round_timer_ctrl #(
    parameter int MS_PER_SEC = 1000,
    parameter int MAX_SEC    = 99,
    parameter int WARN_SEC   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic [6:0] load_sec,
    input  logic       tick_ms,
    output logic       tick_en,
    output logic [6:0] sec_left,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       running,
    output logic       paused,
    output logic       warn,
    output logic       expired,
    output logic       done
);

    localparam int MSW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [MSW-1:0] MS_LAST = MSW'(MS_PER_SEC - 1);
    localparam logic [6:0] MAX7  = 7'(MAX_SEC);
    localparam logic [6:0] WARN7 = 7'(WARN_SEC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [MSW-1:0] ms_q;
    logic [MSW-1:0] ms_d;
    logic [6:0]     sec_d;
    logic           exp_d;
    logic [6:0]     load_clamp;

    // Round length limited to what two BCD digits can show.
    assign load_clamp = (load_sec > MAX7) ? MAX7 : load_sec;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ms_q     <= '0;
            sec_left <= '0;
            tick_en  <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_q     <= ms_d;
            sec_left <= sec_d;
            tick_en  <= (state_d == RUN);
            expired  <= exp_d;
        end
    end

    // Next state; abort beats start beats pause beats tick.
    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        sec_d   = sec_left;
        exp_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            ms_d    = '0;
            sec_d   = '0;
        end else if (start) begin
            ms_d  = '0;
            sec_d = load_clamp;
            if (load_clamp != 7'd0) begin
                state_d = RUN;
            end else begin
                state_d = EXPIRED;
                exp_d   = 1'b1;
            end
        end else if (pause) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end else if (state_q == PAUSE) begin
                state_d = RUN;
            end
        end else if (tick_ms && state_q == RUN) begin
            if (ms_q != MS_LAST) begin
                ms_d = ms_q + 1'b1;
            end else begin
                ms_d = '0;
                if (sec_left != 7'd0) begin
                    sec_d = sec_left - 7'd1;
                end
                if (sec_left == 7'd1) begin
                    state_d = EXPIRED;
                    exp_d   = 1'b1;
                end
            end
        end
    end

    // Status flags decoded from the state register.
    always_comb begin
        running = (state_q == RUN);
        paused  = (state_q == PAUSE);
        done    = (state_q == EXPIRED);
        warn    = (running || paused) && (sec_left != 7'd0)
                  && (sec_left <= WARN7);
    end

    // Binary to two-digit BCD by repeated subtraction of ten.
    always_comb begin
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = sec_left;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        bcd_tens = tens;
        bcd_ones = rem[3:0];
    end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl.
// Runs with 4 ms per second and a 2 s warning threshold.
module tb_round_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic       abort;
    logic [6:0] load_sec;
    logic       tick_ms;
    logic       tick_en;
    logic [6:0] sec_left;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       paused;
    logic       warn;
    logic       expired;
    logic       done;

    int errs;
    int checks;
    int exp_cnt;

    round_timer_ctrl #(
        .MS_PER_SEC(4),
        .MAX_SEC(99),
        .WARN_SEC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pause(pause),
        .abort(abort),
        .load_sec(load_sec),
        .tick_ms(tick_ms),
        .tick_en(tick_en),
        .sec_left(sec_left),
        .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones),
        .running(running),
        .paused(paused),
        .warn(warn),
        .expired(expired),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count timeout pulses between clock edges.
    always @(negedge clk) begin
        if (expired) exp_cnt++;
    end

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One tick, then four quiet cycles.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1;
            cyc();
            tick_ms = 1'b0;
            repeat (4) cyc();
        end
    endtask

    task automatic do_start(input int secs);
        load_sec = 7'(secs);
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
    endtask

    task automatic idle_outs(input string tag);
        check({tag, " sec"}, sec_left, 0);
        check({tag, " tick_en"}, tick_en, 0);
        check({tag, " running"}, running, 0);
        check({tag, " paused"}, paused, 0);
        check({tag, " warn"}, warn, 0);
        check({tag, " expired"}, expired, 0);
        check({tag, " done"}, done, 0);
        check({tag, " tens"}, bcd_tens, 0);
        check({tag, " ones"}, bcd_ones, 0);
    endtask

    initial begin
        errs     = 0;
        checks   = 0;
        exp_cnt  = 0;
        rst      = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        abort    = 1'b0;
        load_sec = 7'd0;
        tick_ms  = 1'b0;

        // Reset and idle with ticks.
        repeat (3) cyc();
        idle_outs("rst");
        rst = 1'b1;
        tick_n(4);
        idle_outs("idle");
        do_pause();
        check("idle pause", paused, 0);
        check("idle no exp", exp_cnt, 0);

        // Full countdown from 3.
        do_start(3);
        check("s3 tick_en", tick_en, 1);
        check("s3 running", running, 1);
        check("s3 sec", sec_left, 3);
        check("s3 warn", warn, 0);
        tick_n(3);
        check("s3 t3 sec", sec_left, 3);
        tick_n(1);
        check("s3 t4 sec", sec_left, 2);
        check("s3 t4 warn", warn, 1);
        check("s3 t4 ones", bcd_ones, 2);
        tick_n(4);
        check("s3 t8 sec", sec_left, 1);
        check("s3 t8 warn", warn, 1);
        tick_n(3);
        tick_ms = 1'b1;
        cyc();
        tick_ms = 1'b0;
        check("t12 expired", expired, 1);
        check("t12 sec", sec_left, 0);
        check("t12 done", done, 1);
        check("t12 tick_en", tick_en, 0);
        check("t12 running", running, 0);
        check("t12 warn", warn, 0);
        cyc();
        check("t13 expired", expired, 0);
        check("t13 done", done, 1);
        check("t13 tens", bcd_tens, 0);
        check("t13 ones", bcd_ones, 0);
        tick_n(2);
        check("exp hold sec", sec_left, 0);
        check("exp hold done", done, 1);

        // Pause keeps the ms count.
        do_start(3);
        check("p start done", done, 0);
        tick_n(2);
        do_pause();
        check("p paused", paused, 1);
        check("p running", running, 0);
        check("p tick_en", tick_en, 0);
        tick_n(10);
        check("p hold sec", sec_left, 3);
        check("p hold paused", paused, 1);
        do_pause();
        check("r running", running, 1);
        check("r tick_en", tick_en, 1);
        tick_n(1);
        check("r t1 sec", sec_left, 3);
        tick_n(1);
        check("r t2 sec", sec_left, 2);

        // Tick and pause in the same cycle.
        do_start(5);
        tick_n(6);
        check("tp sec", sec_left, 4);
        tick_ms = 1'b1;
        pause   = 1'b1;
        cyc();
        tick_ms = 1'b0;
        pause   = 1'b0;
        check("tp paused", paused, 1);
        do_pause();
        tick_n(1);
        check("tp t1 sec", sec_left, 4);
        tick_n(1);
        check("tp t2 sec", sec_left, 3);

        // Abort wins over start and pause.
        load_sec = 7'd7;
        abort    = 1'b1;
        start    = 1'b1;
        pause    = 1'b1;
        cyc();
        abort    = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        idle_outs("abort");
        cyc();
        check("abort no exp", exp_cnt, 1);

        // Zero-length round.
        do_start(0);
        check("z expired", expired, 1);
        check("z done", done, 1);
        check("z running", running, 0);
        cyc();
        check("z exp drop", expired, 0);
        check("z pulses", exp_cnt, 2);

        // Clamp and BCD.
        do_start(47);
        check("b47 tens", bcd_tens, 4);
        check("b47 ones", bcd_ones, 7);
        do_start(120);
        check("clamp sec", sec_left, 99);
        check("clamp tens", bcd_tens, 9);
        check("clamp ones", bcd_ones, 9);
        check("clamp run", running, 1);

        // Asynchronous reset mid-round.
        tick_n(1);
        #2;
        rst = 1'b0;
        #1;
        idle_outs("arst");
        tick_n(2);
        #3;
        rst = 1'b1;
        tick_n(3);
        do_pause();
        idle_outs("post");
        do_start(2);
        check("post sec", sec_left, 2);
        check("post warn", warn, 1);
        check("post running", running, 1);
        check("total pulses", exp_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
